// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage register file.
//
// Consumes the MEM/WB latch outputs. It selects the writeback data
// (jal > lui > MemToReg > PortOut) and commits it to a 2**REG_AW entry
// register file. Register 0 is hard-wired to zero. The read ports bypass
// the value being committed in the same cycle, so the decode stage sees it
// without a stall. The block also holds a sticky halt flag and a saturating
// retired-instruction counter.
//
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   wb_valid        latch holds a real instruction (0 = bubble)
//   wb_RegWr        instruction writes a register
//   wb_MemToReg     write data comes from wb_dmemload
//   wb_jal          jal: write wb_npc to r31
//   wb_lui          lui: write {wb_instr[15:0], 16'h0}
//   wb_halt         halt instruction
//   wb_instr        instruction word (immediate in [15:0])
//   wb_dmemload     load data
//   wb_PortOut      ALU result
//   wb_npc          pc+4 of the instruction
//   wb_wsel         destination register
//   rsel1, rsel2    decode-stage read selects
//   rdat1, rdat2    read data (combinational, bypassed)
//   fwd_wen         commit enable this cycle (combinational)
//   fwd_wsel        effective destination (combinational)
//   fwd_wdat        effective write data (combinational)
//   halt            sticky halt (registered)
//   retired         retired-instruction count (registered, saturating)
module wb_regfile #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wb_valid,
  input  logic              wb_RegWr,
  input  logic              wb_MemToReg,
  input  logic              wb_jal,
  input  logic              wb_lui,
  input  logic              wb_halt,
  input  logic [WORD_W-1:0] wb_instr,
  input  logic [WORD_W-1:0] wb_dmemload,
  input  logic [WORD_W-1:0] wb_PortOut,
  input  logic [WORD_W-1:0] wb_npc,
  input  logic [REG_AW-1:0] wb_wsel,
  input  logic [REG_AW-1:0] rsel1,
  input  logic [REG_AW-1:0] rsel2,
  output logic [WORD_W-1:0] rdat1,
  output logic [WORD_W-1:0] rdat2,
  output logic              fwd_wen,
  output logic [REG_AW-1:0] fwd_wsel,
  output logic [WORD_W-1:0] fwd_wdat,
  output logic              halt,
  output logic [CNT_W-1:0]  retired
);

  localparam int NREG = 2 ** REG_AW;

  logic [WORD_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  retired_cnt;
  logic              halt_q;

  // Only the low half of the instruction (the immediate) feeds lui.
  logic unused_instr_hi;
  assign unused_instr_hi = ^wb_instr[WORD_W-1:16];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Writeback data select and effective destination
  always_comb begin
    fwd_wdat = wb_PortOut;
    if (wb_jal)           fwd_wdat = wb_npc;
    else if (wb_lui)      fwd_wdat = {wb_instr[15:0], 16'h0000};
    else if (wb_MemToReg) fwd_wdat = wb_dmemload;
  end

  // jal always links into the top register (r31 for REG_AW=5).
  assign fwd_wsel = wb_jal ? {REG_AW{1'b1}} : wb_wsel;

  // The halt instruction itself and everything after it never commit.
  assign fwd_wen = wb_valid & (wb_RegWr | wb_jal) & ~wb_halt & ~halt_q &
                   (fwd_wsel != '0);

  // Read ports: r0 is constant zero, otherwise bypass the in-flight commit.
  assign rdat1 = (rsel1 == '0) ? '0 :
                 (fwd_wen && rsel1 == fwd_wsel) ? fwd_wdat : regs[rsel1];
  assign rdat2 = (rsel2 == '0) ? '0 :
                 (fwd_wen && rsel2 == fwd_wsel) ? fwd_wdat : regs[rsel2];

  // Register array commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (fwd_wen) begin
      regs[fwd_wsel] <= fwd_wdat;
    end
  end

  // Halt flag and retired counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q      <= 1'b0;
      retired_cnt <= '0;
    end else if (wb_valid && !halt_q) begin
      retired_cnt <= sat_inc(retired_cnt);
      if (wb_halt) halt_q <= 1'b1;
    end
  end

  assign halt    = halt_q;
  assign retired = retired_cnt;

endmodule
